// File: rtl/fb_pkg.sv
// fb_pkg: shared constants, FSM state type and pixel packing helper for the
// double-buffered frame-buffer writer.
//   - Window constants: START_X/START_Y (first column/row), END_X/END_Y
//     (exclusive bounds), REGION_DIVIDE (rows below it form the cylinder
//     region), CYL_SHIFT (column correction applied there).
//   - Derived sizes: W, H and the per-bank DEPTH = W*H.
//   - fb_state_t: writer FSM states.
//   - pack_rgb444(): RGB888 {R,G,B} to RGB444 by keeping each channel's top nibble.
package fb_pkg;

    localparam int START_X       = 390;
    localparam int START_Y       = 390;
    localparam int END_X         = 634;
    localparam int END_Y         = 765;
    localparam int REGION_DIVIDE = 530;
    localparam int CYL_SHIFT     = 2;
    localparam int ADDR_W        = 17;

    localparam int W     = END_X - START_X;   // 244
    localparam int H     = END_Y - START_Y;   // 375
    localparam int DEPTH = W * H;             // 91500

    typedef enum logic [0:0] {
        FILL      = 1'b0,
        WAIT_SWAP = 1'b1
    } fb_state_t;

    function automatic logic [11:0] pack_rgb444(input logic [23:0] rgb);
        return {rgb[23:20], rgb[15:12], rgb[7:4]};
    endfunction

endpackage

// File: rtl/fb_double_writer_if.sv
// fb_double_writer_if: pixel stream from the renderer into the frame-buffer
// writer. Carries the AXI-stream beat plus its hcount/vcount sideband, which
// is coincident with tdata.
//   master : renderer side (drives data, valid and sideband; sees tready)
//   slave  : writer side   (sees data, valid and sideband; drives tready)
interface fb_double_writer_if;

    logic [23:0] pixel_axis_tdata;
    logic        pixel_axis_tvalid;
    logic        pixel_axis_tready;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;

    modport master (
        output pixel_axis_tdata,
        output pixel_axis_tvalid,
        output hcount_in,
        output vcount_in,
        input  pixel_axis_tready
    );

    modport slave (
        input  pixel_axis_tdata,
        input  pixel_axis_tvalid,
        input  hcount_in,
        input  vcount_in,
        output pixel_axis_tready
    );

endinterface

// File: rtl/fb_addr_calc.sv
// fb_addr_calc: two-stage pipeline turning an accepted pixel beat into a
// BRAM write.
//   Stage 1 registers the corrected column, row*W, the in-window flag, the
//   RGB444 data and the target bank. Stage 2 adds column and row*W and drives
//   the write port.
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   in_valid             beat accepted this cycle
//   hcount, vcount, rgb  beat position and RGB888 data
//   bank                 back bank to write into, sampled with the beat
//   wr_en/wr_addr/wr_data registered BRAM write port, wr_addr = {bank, index}
//   busy                 a beat is still in stage 1 or stage 2
module fb_addr_calc
    import fb_pkg::*;
#(
    parameter int START_X       = fb_pkg::START_X,
    parameter int START_Y       = fb_pkg::START_Y,
    parameter int END_X         = fb_pkg::END_X,
    parameter int END_Y         = fb_pkg::END_Y,
    parameter int REGION_DIVIDE = fb_pkg::REGION_DIVIDE,
    parameter int CYL_SHIFT     = fb_pkg::CYL_SHIFT,
    parameter int ADDR_W        = fb_pkg::ADDR_W
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              in_valid,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    input  logic [23:0]       rgb,
    input  logic              bank,
    output logic              wr_en,
    output logic [ADDR_W:0]   wr_addr,
    output logic [11:0]       wr_data,
    output logic              busy
);

    localparam int WIN_W = END_X - START_X;
    localparam int WIN_H = END_Y - START_Y;

    // Two's-complement column (12 bits) and row (11 bits); the MSB is the sign.
    logic [11:0]       col_c;
    logic [10:0]       row_c;
    logic              in_win_c;
    logic [ADDR_W-1:0] row_w_c;

    // NOTE: every always_comb output gets an unconditional assignment first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        col_c = {1'b0, hcount} - 12'(START_X);
        if (vcount < 10'(REGION_DIVIDE)) begin
            col_c = col_c - 12'(CYL_SHIFT);
        end
        row_c    = {1'b0, vcount} - 11'(START_Y);
        in_win_c = !col_c[11] && (col_c[10:0] < 11'(WIN_W)) &&
                   !row_c[10] && (row_c[9:0]  < 10'(WIN_H));
        // Only meaningful inside the window, where row < H keeps it in range.
        row_w_c  = ADDR_W'(row_c[9:0]) * ADDR_W'(WIN_W);
    end

    logic              s1_valid;
    logic              s1_in_win;
    logic              s1_bank;
    logic [ADDR_W-1:0] s1_col;
    logic [ADDR_W-1:0] s1_row_w;
    logic [11:0]       s1_data;
    logic              s2_valid;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid  <= 1'b0;
            s1_in_win <= 1'b0;
            s1_bank   <= 1'b0;
            s1_col    <= '0;
            s1_row_w  <= '0;
            s1_data   <= '0;
            s2_valid  <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_in_win <= in_win_c;
                s1_bank   <= bank;
                s1_col    <= ADDR_W'(col_c[10:0]);
                s1_row_w  <= row_w_c;
                s1_data   <= pack_rgb444(rgb);
            end
            s2_valid <= s1_valid;
            wr_en    <= s1_valid && s1_in_win;
            if (s1_valid) begin
                wr_addr <= {s1_bank, s1_col + s1_row_w};
                wr_data <= s1_data;
            end
        end
    end

    assign busy = s1_valid || s2_valid;

endmodule

// File: rtl/fb_double_writer.sv
// fb_double_writer: double-buffered frame-buffer write stage.
// Accepts renderer pixels, writes them as RGB444 into the back bank of a
// two-bank BRAM (instantiated by the parent), and after the last beat of a
// frame stalls the renderer until the display's vblank pulse swaps banks.
// Ports:
//   aclk, aresetn     clock, asynchronous active-low reset
//   pix               pixel stream (slave side), tready decoded from state
//   swap_in           one-cycle vblank-start pulse from the display
//   wr_en_out         BRAM write enable
//   wr_addr_out       {bank, index} write address
//   wr_data_out       RGB444 pixel
//   rd_bank_out       front bank, used by the display as its address MSB
//   frame_done_out    one-cycle pulse after each swap
//   frame_count_out   completed swaps, wraps at 256
module fb_double_writer
    import fb_pkg::*;
#(
    parameter int START_X       = fb_pkg::START_X,
    parameter int START_Y       = fb_pkg::START_Y,
    parameter int END_X         = fb_pkg::END_X,
    parameter int END_Y         = fb_pkg::END_Y,
    parameter int REGION_DIVIDE = fb_pkg::REGION_DIVIDE,
    parameter int CYL_SHIFT     = fb_pkg::CYL_SHIFT,
    parameter int ADDR_W        = fb_pkg::ADDR_W
) (
    input  logic                aclk,
    input  logic                aresetn,
    fb_double_writer_if.slave   pix,
    input  logic                swap_in,
    output logic                wr_en_out,
    output logic [ADDR_W:0]     wr_addr_out,
    output logic [11:0]         wr_data_out,
    output logic                rd_bank_out,
    output logic                frame_done_out,
    output logic [7:0]          frame_count_out
);

    fb_state_t state_q, state_d;
    logic      tready;
    logic      accept;
    logic      do_swap;
    logic      busy;
    logic      last_beat;

    // Raw hcount is used here, not the cylinder-corrected column.
    assign last_beat = (pix.hcount_in == 11'(END_X - 1)) &&
                       (pix.vcount_in == 10'(END_Y - 1));

    always_comb begin
        state_d = state_q;
        tready  = 1'b0;
        accept  = 1'b0;
        do_swap = 1'b0;
        unique case (state_q)
            FILL: begin
                // Gated by reset so the renderer is held off while reset is low.
                tready = aresetn;
                accept = pix.pixel_axis_tvalid && aresetn;
                if (accept && last_beat) begin
                    state_d = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                // A vblank that arrives while writes are still in flight is
                // skipped; the next one completes the swap.
                if (swap_in && !busy) begin
                    do_swap = 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign pix.pixel_axis_tready = tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q         <= FILL;
            rd_bank_out     <= 1'b0;
            frame_done_out  <= 1'b0;
            frame_count_out <= '0;
        end else begin
            state_q        <= state_d;
            frame_done_out <= do_swap;
            if (do_swap) begin
                rd_bank_out     <= ~rd_bank_out;
                frame_count_out <= frame_count_out + 8'd1;
            end
        end
    end

    fb_addr_calc #(
        .START_X       (START_X),
        .START_Y       (START_Y),
        .END_X         (END_X),
        .END_Y         (END_Y),
        .REGION_DIVIDE (REGION_DIVIDE),
        .CYL_SHIFT     (CYL_SHIFT),
        .ADDR_W        (ADDR_W)
    ) u_addr_calc (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .in_valid (accept),
        .hcount   (pix.hcount_in),
        .vcount   (pix.vcount_in),
        .rgb      (pix.pixel_axis_tdata),
        .bank     (~rd_bank_out),
        .wr_en    (wr_en_out),
        .wr_addr  (wr_addr_out),
        .wr_data  (wr_data_out),
        .busy     (busy)
    );

endmodule

// File: tb/tb_fb_double_writer.sv
// tb_fb_double_writer: self-checking bench for fb_double_writer.
// Table of single-beat vectors, a randomized back-to-back stream checked
// against a behavioural address model, and hand-written sequences for frame
// end, bank swap, reset mid-frame and frame-counter wrap.
module tb_fb_double_writer;

    logic        aclk    = 1'b0;
    logic        aresetn = 1'b0;
    logic        swap_in = 1'b0;
    logic        wr_en;
    logic [17:0] wr_addr;
    logic [11:0] wr_data;
    logic        rd_bank;
    logic        frame_done;
    logic [7:0]  frame_count;

    int total = 0;
    int bad   = 0;

    logic       exp_rd_bank = 1'b0;
    logic [7:0] exp_count   = 8'd0;

    fb_double_writer_if pif ();

    fb_double_writer dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .pix             (pif),
        .swap_in         (swap_in),
        .wr_en_out       (wr_en),
        .wr_addr_out     (wr_addr),
        .wr_data_out     (wr_data),
        .rd_bank_out     (rd_bank),
        .frame_done_out  (frame_done),
        .frame_count_out (frame_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int          h;
        int          v;
        logic [23:0] d;
        logic        en;
        int          idx;
        logic [11:0] data;
    } vec_t;

    typedef struct {
        logic        en;
        logic [17:0] addr;
        logic [11:0] data;
    } exp_t;

    vec_t vecs [12];
    exp_t exp_q [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference: window mapping straight from the geometric rules.
    function automatic void model(input int h, input int v, input logic [23:0] d,
                                  input logic bank, output exp_t e);
        int col;
        int row;
        col    = h - 390 - ((v < 530) ? 2 : 0);
        row    = v - 390;
        e.en   = (col >= 0) && (col < 244) && (row >= 0) && (row < 375);
        e.addr = {bank, 17'(e.en ? (col + row * 244) : 0)};
        e.data = {d[23:20], d[15:12], d[7:4]};
    endfunction

    task automatic drive(input int h, input int v, input logic [23:0] d, input logic vld);
        pif.hcount_in         = 11'(h);
        pif.vcount_in         = 10'(v);
        pif.pixel_axis_tdata  = d;
        pif.pixel_axis_tvalid = vld;
    endtask

    // Starts and ends just after a negedge.
    task automatic send_check(input string name, input int h, input int v,
                              input logic [23:0] d, input exp_t e);
        drive(h, v, d, 1'b1);
        check({name, "_rdy"}, 32'(pif.pixel_axis_tready), 32'd1);
        @(posedge aclk);
        @(negedge aclk);
        pif.pixel_axis_tvalid = 1'b0;
        check({name, "_lat1"}, 32'(wr_en), 32'd0);
        @(posedge aclk);
        @(negedge aclk);
        check({name, "_en"}, 32'(wr_en), 32'(e.en));
        if (e.en) begin
            check({name, "_addr"}, 32'(wr_addr), 32'(e.addr));
            check({name, "_data"}, 32'(wr_data), 32'(e.data));
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    // One short frame: a random in-window pixel, the last pixel, an early
    // (ignored) vblank at T+2 and the earliest legal one at T+3.
    task automatic do_frame(input int f);
        exp_t        e;
        int          h;
        int          v;
        logic [23:0] d;
        h = int'($urandom_range(632, 392));
        v = int'($urandom_range(763, 530));
        d = 24'($urandom);
        model(h, v, d, ~exp_rd_bank, e);
        send_check($sformatf("frm%0d_px", f), h, v, d, e);
        d = 24'($urandom);
        e.en   = 1'b1;
        e.addr = {~exp_rd_bank, 17'd91499};
        e.data = {d[23:20], d[15:12], d[7:4]};
        send_check($sformatf("frm%0d_last", f), 633, 764, d, e);
        check($sformatf("frm%0d_stall", f), 32'(pif.pixel_axis_tready), 32'd0);
        swap_in = 1'b1;
        tick();
        check($sformatf("frm%0d_early_bank", f), 32'(rd_bank), 32'(exp_rd_bank));
        check($sformatf("frm%0d_early_done", f), 32'(frame_done), 32'd0);
        tick();
        swap_in     = 1'b0;
        exp_rd_bank = ~exp_rd_bank;
        exp_count   = exp_count + 8'd1;
        check($sformatf("frm%0d_done", f), 32'(frame_done), 32'd1);
        check($sformatf("frm%0d_bank", f), 32'(rd_bank), 32'(exp_rd_bank));
        check($sformatf("frm%0d_count", f), 32'(frame_count), 32'(exp_count));
        check($sformatf("frm%0d_rdy", f), 32'(pif.pixel_axis_tready), 32'd1);
        tick();
        check($sformatf("frm%0d_done_off", f), 32'(frame_done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   h;
        int   v;
        logic [23:0] d;
        logic vld;

        vecs[0]  = '{390, 600, 24'hF0A05C, 1'b1, 51240, 12'hFA5};
        vecs[1]  = '{392, 390, 24'h123456, 1'b1, 0,     12'h135};
        vecs[2]  = '{390, 390, 24'hFFFFFF, 1'b0, 0,     12'h000};
        vecs[3]  = '{633, 600, 24'hABCDEF, 1'b1, 51483, 12'hACE};
        vecs[4]  = '{634, 600, 24'hABCDEF, 1'b0, 0,     12'h000};
        vecs[5]  = '{389, 700, 24'h123456, 1'b0, 0,     12'h000};
        vecs[6]  = '{390, 764, 24'h0F0F0F, 1'b1, 91256, 12'h000};
        vecs[7]  = '{390, 765, 24'h123456, 1'b0, 0,     12'h000};
        vecs[8]  = '{392, 529, 24'hFFFFFF, 1'b1, 33916, 12'hFFF};
        vecs[9]  = '{391, 529, 24'hFFFFFF, 1'b0, 0,     12'h000};
        vecs[10] = '{390, 530, 24'h123456, 1'b1, 34160, 12'h135};
        vecs[11] = '{635, 529, 24'hABCDEF, 1'b1, 34159, 12'hACE};

        drive(0, 0, 24'h0, 1'b0);

        // Reset state.
        repeat (3) @(negedge aclk);
        check("rst_tready", 32'(pif.pixel_axis_tready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_rd_bank", 32'(rd_bank), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_count", 32'(frame_count), 32'd0);
        aresetn = 1'b1;
        tick();
        check("post_rst_tready", 32'(pif.pixel_axis_tready), 32'd1);

        // Table vectors, written into back bank 1.
        for (int i = 0; i < 12; i++) begin
            e.en   = vecs[i].en;
            e.addr = {1'b1, 17'(vecs[i].idx)};
            e.data = vecs[i].data;
            send_check($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].d, e);
        end

        // Randomized stream at full rate against the model (2-cycle delay queue).
        exp_q.delete();
        for (int c = 0; c < 302; c++) begin
            if (exp_q.size() == 2) begin
                e = exp_q.pop_front();
                check($sformatf("rnd%0d_en", c), 32'(wr_en), 32'(e.en));
                if (e.en) begin
                    check($sformatf("rnd%0d_addr", c), 32'(wr_addr), 32'(e.addr));
                    check($sformatf("rnd%0d_data", c), 32'(wr_data), 32'(e.data));
                end
            end
            if (c < 300) begin
                vld = ($urandom_range(3) != 0);
                h   = int'($urandom_range(640, 380));
                v   = int'($urandom_range(770, 380));
                if (h == 633 && v == 764) h = 632;
                d   = 24'($urandom);
                drive(h, v, d, vld);
                model(h, v, d, 1'b1, e);
                if (!vld) e.en = 1'b0;
            end else begin
                pif.pixel_axis_tvalid = 1'b0;
                e.en = 1'b0;
            end
            exp_q.push_back(e);
            tick();
        end
        exp_q.delete();

        // Last beat, ignored swap at T+1, accepted swap at T+5.
        drive(633, 764, 24'h808080, 1'b1);
        tick();
        pif.pixel_axis_tvalid = 1'b0;
        check("last_tready_drop", 32'(pif.pixel_axis_tready), 32'd0);
        swap_in = 1'b1;
        tick();
        swap_in = 1'b0;
        check("last_en", 32'(wr_en), 32'd1);
        check("last_addr", 32'(wr_addr), {14'd0, 1'b1, 17'd91499});
        check("last_data", 32'(wr_data), 32'h888);
        check("swap_t1_bank", 32'(rd_bank), 32'd0);
        check("swap_t1_done", 32'(frame_done), 32'd0);
        tick();
        tick();
        tick();
        check("wait_tready", 32'(pif.pixel_axis_tready), 32'd0);
        check("wait_bank", 32'(rd_bank), 32'd0);
        swap_in = 1'b1;
        tick();
        swap_in     = 1'b0;
        exp_rd_bank = 1'b1;
        exp_count   = 8'd1;
        check("swap_bank", 32'(rd_bank), 32'd1);
        check("swap_done", 32'(frame_done), 32'd1);
        check("swap_count", 32'(frame_count), 32'd1);
        check("swap_tready", 32'(pif.pixel_axis_tready), 32'd1);
        tick();
        check("swap_done_pulse", 32'(frame_done), 32'd0);

        // Swap during FILL with a partial frame is ignored; writes go to bank 0.
        model(500, 600, 24'h13579B, 1'b0, e);
        send_check("fill_px", 500, 600, 24'h13579B, e);
        swap_in = 1'b1;
        tick();
        swap_in = 1'b0;
        tick();
        check("fill_swap_bank", 32'(rd_bank), 32'd1);
        check("fill_swap_count", 32'(frame_count), 32'd1);
        check("fill_swap_done", 32'(frame_done), 32'd0);
        check("fill_swap_tready", 32'(pif.pixel_axis_tready), 32'd1);

        // Reset mid-frame with beats in flight.
        drive(400, 600, 24'hFFFFFF, 1'b1);
        @(posedge aclk);
        pif.hcount_in = 11'd401;
        @(posedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_addr", 32'(wr_addr), 32'd0);
        check("mid_rst_data", 32'(wr_data), 32'd0);
        check("mid_rst_bank", 32'(rd_bank), 32'd0);
        check("mid_rst_done", 32'(frame_done), 32'd0);
        check("mid_rst_count", 32'(frame_count), 32'd0);
        check("mid_rst_tready", 32'(pif.pixel_axis_tready), 32'd0);
        @(negedge aclk);
        pif.pixel_axis_tvalid = 1'b0;
        tick();
        check("mid_rst_hold_en", 32'(wr_en), 32'd0);
        aresetn     = 1'b1;
        exp_rd_bank = 1'b0;
        exp_count   = 8'd0;
        tick();
        check("mid_rst_flush_en", 32'(wr_en), 32'd0);
        e.en   = 1'b1;
        e.addr = {1'b1, 17'd51240};
        e.data = 12'hFA5;
        send_check("post_rst_px", 390, 600, 24'hF0A05C, e);

        // 256 frames: counter wraps to 0, front bank returns to 0.
        for (int f = 0; f < 256; f++) begin
            do_frame(f);
        end
        check("wrap_count", 32'(frame_count), 32'd0);
        check("wrap_bank", 32'(rd_bank), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
